// File: rtl/vram_tile_memory_mc_pkg.sv
// Shared types, default geometry and helpers for the multi-channel tile memory.
// Pure declarations: no logic, no latency.
// Not applicable: no flow control lives here.
package vram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } vram_state_t;

  localparam int WRITE_WIDTH_DEF = 16;
  localparam int LINE_WIDTH_DEF  = 256;
  localparam int NUM_LINES_DEF   = 2048;

  // Pointer width that never collapses to zero bits for a single-entry range.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vram_tile_memory_mc_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the priority pointer.
// Latency: grant is combinational in the request cycle; pointer moves on the grant edge.
// Backpressure: losers simply keep requesting; at most one grant per cycle.
module rr_arbiter
  import vram_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PTR_W = clog2_min1(N);
  localparam logic [PTR_W:0]   N_W  = (PTR_W+1)'(N);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(N - 1);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic [N-1:0]     gnt;
  logic             found;

  // Scan from the pointer with wrap-around; first hit wins and the pointer moves past it.
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (sum >= N_W) sum = sum - N_W;
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_d    = (idx == LAST) ? '0 : idx + PTR_W'(1);
      end
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  // No grant may escape while reset is held, even though the scan itself is combinational.
  assign grant = rst ? '0 : gnt;

endmodule

// File: rtl/vram_tile_memory_mc.sv
// Banked tile memory: narrow pixel-pair writes, NUM_READ_CH arbitrated wide line reads, zero-fill engine.
// Latency: read data and one-hot rd_valid appear 2 cycles after the grant cycle; one read per cycle sustained.
// Backpressure: requesters hold rd_req until granted; CPU writes are dropped while a clear is running.
module vram_tile_memory_mc
  import vram_pkg::*;
#(
  parameter  int WRITE_WIDTH = WRITE_WIDTH_DEF,
  parameter  int LINE_WIDTH  = LINE_WIDTH_DEF,
  parameter  int NUM_LINES   = NUM_LINES_DEF,
  parameter  int NUM_READ_CH = 2,
  localparam int LANES       = LINE_WIDTH / WRITE_WIDTH,
  localparam int LADDR_W     = $clog2(NUM_LINES),
  localparam int LANE_W      = $clog2(LANES),
  localparam int WADDR_W     = LADDR_W + LANE_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           write_enable,
  input  logic [WADDR_W-1:0]             write_addr,
  input  logic [WRITE_WIDTH-1:0]         write_data,
  input  logic [NUM_READ_CH-1:0]         rd_req,
  input  logic [NUM_READ_CH*LADDR_W-1:0] rd_addr,
  output logic [NUM_READ_CH-1:0]         rd_grant,
  output logic [NUM_READ_CH-1:0]         rd_valid,
  output logic [LINE_WIDTH-1:0]          rd_data,
  input  logic                           clear_start,
  output logic                           clear_busy
);

  localparam logic [LADDR_W-1:0] LAST_LINE = LADDR_W'(NUM_LINES - 1);

  vram_state_t                state_q, state_d;
  logic [LADDR_W-1:0]         clr_cnt_q, clr_cnt_d;
  logic [NUM_READ_CH-1:0]     s1_vld_q, s1_vld_d;
  logic [NUM_READ_CH-1:0]     rd_valid_q, rd_valid_d;
  logic [LINE_WIDTH-1:0]      rd_data_q, rd_data_d;
  logic [LINE_WIDTH-1:0]      bank_line;
  logic [NUM_READ_CH-1:0]     grant;
  logic [LADDR_W-1:0]         raddr;
  logic                       rd_fire;
  logic                       mem_we;
  logic                       mem_all_lanes;
  logic [LADDR_W-1:0]         mem_line;
  logic [LANE_W-1:0]          mem_lane;
  logic [WRITE_WIDTH-1:0]     mem_wdat;

  rr_arbiter #(.N(NUM_READ_CH)) u_arb (
    .clk   (clk),
    .rst   (reset),
    .req   (rd_req),
    .grant (grant)
  );

  // Select the granted channel's line address for the bank read.
  always_comb begin
    raddr   = '0;
    rd_fire = |grant;
    for (int c = 0; c < NUM_READ_CH; c++) begin
      if (grant[c]) raddr = rd_addr[c*LADDR_W +: LADDR_W];
    end
  end

  // Clear FSM and the single bank write port: CPU word in IDLE, full zero line per cycle in CLEAR.
  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    mem_we        = 1'b0;
    mem_all_lanes = 1'b0;
    mem_line      = write_addr[WADDR_W-1:LANE_W];
    mem_lane      = write_addr[LANE_W-1:0];
    mem_wdat      = write_data;
    case (state_q)
      IDLE: begin
        mem_we = write_enable;
        if (clear_start) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        mem_we        = 1'b1;
        mem_all_lanes = 1'b1;
        mem_line      = clr_cnt_q;
        mem_wdat      = '0;
        if (clr_cnt_q == LAST_LINE) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + LADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One simple dual-port RAM per lane; the read samples before the same-edge write lands.
  for (genvar k = 0; k < LANES; k++) begin : g_bank
    logic [WRITE_WIDTH-1:0] mem [NUM_LINES];
    logic [WRITE_WIDTH-1:0] bank_rd_q;
    logic                   lane_we;

    assign lane_we = mem_we && (mem_all_lanes || (mem_lane == LANE_W'(k)));

    // Bank storage and registered read port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
      if (lane_we) mem[mem_line] <= mem_wdat;
      if (rd_fire) bank_rd_q <= mem[raddr];
    end

    assign bank_line[k*WRITE_WIDTH +: WRITE_WIDTH] = bank_rd_q;
  end

  // Second pipeline stage: publish the bank line, otherwise hold the last delivered data.
  always_comb begin
    s1_vld_d   = grant;
    rd_valid_d = s1_vld_q;
    rd_data_d  = (|s1_vld_q) ? bank_line : rd_data_q;
  end

  // Control and output registers; reset drops any reads still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      clr_cnt_q  <= '0;
      s1_vld_q   <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      s1_vld_q   <= s1_vld_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_grant   = grant;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign clear_busy = (state_q == CLEAR);

endmodule

// File: tb/tb_vram_tile_memory_mc.sv
// Scoreboard bench for the tile memory: default 2-channel/256-bit instance plus a 3-channel/128-bit instance.
// Expected lines come from a line-array model updated per clock edge; expected grants from a round-robin model.
// A monitor pops the queue at each expected arrival cycle and checks rd_valid/rd_data, including hold behaviour.
module tb_vram_tile_memory_mc;

  typedef struct {
    logic [7:0]   vld;
    logic [255:0] dat;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- instance A: defaults (2 ch, 256-bit lines, 16 lanes) ----------------
  logic         reset, write_enable, clear_start, clear_busy;
  logic [14:0]  write_addr;
  logic [15:0]  write_data;
  logic [1:0]   rd_req, rd_grant, rd_valid;
  logic [21:0]  rd_addr;
  logic [255:0] rd_data;

  vram_tile_memory_mc dut_a (
    .clk(clk), .reset(reset), .write_enable(write_enable), .write_addr(write_addr),
    .write_data(write_data), .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
    .rd_valid(rd_valid), .rd_data(rd_data), .clear_start(clear_start), .clear_busy(clear_busy)
  );

  logic [255:0] ref_line [2048];
  exp_t         qa[$];
  int           ptr_a = 0;
  bit           clr_act = 0;
  int           clr_idx = 0;
  logic [255:0] last_a = '0;
  logic [1:0]   exp_ga;
  int           ch_a, gch_a, ln_a, lane_a;
  exp_t         ea, pa;

  initial for (int i = 0; i < 2048; i++) ref_line[i] = '0;

  // Reference model for A: predicts grant/busy now, then applies what the coming edge does.
  always @(negedge clk) begin
    if (reset) begin
      qa.delete();
      ptr_a   = 0;
      clr_act = 0;
      chk("a_grant_in_reset", rd_grant, 0);
      chk("a_busy_in_reset", clear_busy, 0);
    end else begin
      chk("a_clear_busy", clear_busy, clr_act);
      exp_ga = '0;
      gch_a  = -1;
      for (int i = 0; i < 2; i++) begin
        ch_a = (ptr_a + i) % 2;
        if (gch_a < 0 && rd_req[ch_a]) gch_a = ch_a;
      end
      if (gch_a >= 0) exp_ga[gch_a] = 1'b1;
      chk("a_grant", rd_grant, exp_ga);
      if (gch_a >= 0) begin
        pa.vld = 8'(exp_ga);
        pa.dat = ref_line[rd_addr[gch_a*11 +: 11]];
        pa.due = cyc + 2;
        qa.push_back(pa);
        ptr_a = (gch_a + 1) % 2;
      end
      if (clr_act) begin
        ref_line[clr_idx] = '0;
        clr_idx++;
        if (clr_idx == 2048) clr_act = 0;
      end else begin
        if (write_enable) begin
          ln_a   = int'(write_addr[14:4]);
          lane_a = int'(write_addr[3:0]);
          ref_line[ln_a][lane_a*16 +: 16] = write_data;
        end
        if (clear_start) begin
          clr_act = 1;
          clr_idx = 0;
        end
      end
    end
  end

  // Monitor for A.
  always @(negedge clk) begin
    if (reset) begin
      chk("a_valid_in_reset", rd_valid, 0);
      chk("a_data_in_reset", rd_data, 0);
      last_a = '0;
    end else if (qa.size() > 0 && qa[0].due == cyc) begin
      ea = qa.pop_front();
      chk("a_rd_valid", rd_valid, ea.vld);
      chk("a_rd_data", rd_data, ea.dat);
      last_a = ea.dat;
    end else begin
      chk("a_no_valid", rd_valid, 0);
      chk("a_data_hold", rd_data, last_a);
    end
  end

  // ---------------- instance B: 3 ch, 128-bit lines, 8 lanes ----------------
  logic         b_reset, b_we, b_clr_start, b_busy;
  logic [13:0]  b_waddr;
  logic [15:0]  b_wdata;
  logic [2:0]   b_req, b_grant, b_valid;
  logic [32:0]  b_addr;
  logic [127:0] b_data;

  vram_tile_memory_mc #(.LINE_WIDTH(128), .NUM_READ_CH(3)) dut_b (
    .clk(clk), .reset(b_reset), .write_enable(b_we), .write_addr(b_waddr),
    .write_data(b_wdata), .rd_req(b_req), .rd_addr(b_addr), .rd_grant(b_grant),
    .rd_valid(b_valid), .rd_data(b_data), .clear_start(b_clr_start), .clear_busy(b_busy)
  );

  logic [127:0] refb [8];
  exp_t         qb[$];
  int           ptr_b = 0;
  logic [127:0] last_b = '0;
  logic [2:0]   exp_gb;
  int           ch_b, gch_b;
  exp_t         eb, pb;

  // Reference model for B (only lines 0..7 are ever touched).
  always @(negedge clk) begin
    if (b_reset) begin
      qb.delete();
      ptr_b = 0;
      chk("b_grant_in_reset", b_grant, 0);
    end else begin
      exp_gb = '0;
      gch_b  = -1;
      for (int i = 0; i < 3; i++) begin
        ch_b = (ptr_b + i) % 3;
        if (gch_b < 0 && b_req[ch_b]) gch_b = ch_b;
      end
      if (gch_b >= 0) exp_gb[gch_b] = 1'b1;
      chk("b_grant", b_grant, exp_gb);
      chk("b_busy", b_busy, 0);
      if (gch_b >= 0) begin
        pb.vld = 8'(exp_gb);
        pb.dat = 256'(refb[b_addr[gch_b*11 +: 3]]);
        pb.due = cyc + 2;
        qb.push_back(pb);
        ptr_b = (gch_b + 1) % 3;
      end
      if (b_we) refb[b_waddr[5:3]][int'(b_waddr[2:0])*16 +: 16] = b_wdata;
    end
  end

  // Monitor for B.
  always @(negedge clk) begin
    if (b_reset) begin
      chk("b_valid_in_reset", b_valid, 0);
      last_b = '0;
    end else if (qb.size() > 0 && qb[0].due == cyc) begin
      eb = qb.pop_front();
      chk("b_rd_valid", b_valid, eb.vld);
      chk("b_rd_data", b_data, eb.dat);
      last_b = eb.dat[127:0];
    end else begin
      chk("b_no_valid", b_valid, 0);
      chk("b_data_hold", b_data, last_b);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int line, input int lane, input logic [15:0] d);
    write_enable = 1'b1;
    write_addr   = {11'(line), 4'(lane)};
    write_data   = d;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic rd(input int ch, input int line);
    rd_req = '0;
    rd_req[ch] = 1'b1;
    rd_addr[ch*11 +: 11] = 11'(line);
    tick();
    rd_req = '0;
  endtask

  initial begin
    reset = 1'b1; write_enable = 1'b0; write_addr = '0; write_data = '0;
    rd_req = '0; rd_addr = '0; clear_start = 1'b0;
    b_reset = 1'b1; b_we = 1'b0; b_waddr = '0; b_wdata = '0;
    b_req = '0; b_addr = '0; b_clr_start = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Full clear; a mid-clear write must not stick.
    clear_start = 1'b1; tick(); clear_start = 1'b0;
    repeat (1000) tick();
    wr(3, 0, 16'h1234);
    repeat (1100) tick();
    rd(0, 0); rd(1, 1023); rd(0, 2047); rd(1, 3);
    repeat (3) tick();

    // Lane mapping on line 1, single-channel read.
    for (int k = 0; k < 16; k++) wr(1, k, 16'h1000 + 16'(k));
    rd(0, 1);
    repeat (3) tick();

    // Both channels requesting every cycle: grants must alternate.
    for (int k = 0; k < 16; k++) wr(2, k, 16'($urandom));
    rd_req = 2'b11; rd_addr = {11'd2, 11'd1};
    repeat (8) tick();
    rd_req = '0;
    repeat (3) tick();

    // Same-edge read/write collision, then a re-read one cycle later.
    wr(5, 0, 16'h1111);
    write_enable = 1'b1; write_addr = {11'd5, 4'd0}; write_data = 16'hBEEF;
    rd_req = 2'b01; rd_addr[10:0] = 11'd5;
    tick();
    write_enable = 1'b0;
    tick();
    rd_req = '0;
    repeat (3) tick();

    // Random traffic over a small line window so reads and writes collide often.
    for (int i = 0; i < 400; i++) begin
      write_enable = 1'($urandom);
      write_addr   = {11'($urandom_range(0, 31)), 4'($urandom)};
      write_data   = 16'($urandom);
      rd_req       = 2'($urandom);
      rd_addr      = {11'($urandom_range(0, 31)), 11'($urandom_range(0, 31))};
      tick();
    end
    write_enable = 1'b0; rd_req = '0;
    repeat (3) tick();

    // Reset with a read in flight.
    rd(0, 7);
    reset = 1'b1; repeat (2) tick(); reset = 1'b0; tick();

    // Reset 100 cycles into a clear leaves a partial clear behind.
    clear_start = 1'b1; tick(); clear_start = 1'b0;
    repeat (100) tick();
    reset = 1'b1; repeat (2) tick(); reset = 1'b0; tick();
    rd_req = 2'b11; rd_addr = {11'd150, 11'd20}; tick(); rd_req = '0;
    wr(9, 3, 16'hCAFE);
    rd(1, 9); rd(0, 99); rd(1, 100);
    repeat (3) tick();

    // Clear with reads racing the clear pointer and ignored writes.
    for (int k = 0; k < 32; k++) wr(k, k % 16, 16'h5A00 + 16'(k));
    clear_start = 1'b1; tick(); clear_start = 1'b0;
    for (int i = 0; i < 80; i++) begin
      rd_req       = 2'($urandom);
      rd_addr      = {11'($urandom_range(0, 63)), 11'($urandom_range(0, 63))};
      write_enable = 1'($urandom);
      write_addr   = {11'($urandom_range(0, 63)), 4'($urandom)};
      write_data   = 16'($urandom);
      tick();
    end
    rd_req = '0; write_enable = 1'b0;
    repeat (2000) tick();
    rd(0, 10); rd(1, 2047);
    repeat (4) tick();

    // Instance B: 8-lane mapping and three-way fairness.
    b_reset = 1'b0; tick();
    for (int l = 0; l < 3; l++)
      for (int k = 0; k < 8; k++) begin
        b_we = 1'b1; b_waddr = {11'(l), 3'(k)}; b_wdata = 16'hA000 + 16'(l*16 + k);
        tick();
      end
    b_we = 1'b0;
    b_req = 3'b111; b_addr = {11'd2, 11'd1, 11'd0};
    repeat (9) tick();
    for (int i = 0; i < 60; i++) begin
      b_req  = 3'($urandom);
      b_addr = {11'($urandom_range(0, 2)), 11'($urandom_range(0, 2)), 11'($urandom_range(0, 2))};
      tick();
    end
    b_req = '0;
    repeat (4) tick();

    chk("a_queue_drained", 256'(qa.size()), 0);
    chk("b_queue_drained", 256'(qb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
